// File: rtl/fetch_decode_pipe.sv
`default_nettype none
// ============================================================================
// fetch_decode_pipe : two-stage MIPS front end (PC/IF, IF/ID register, decode
// with register file). Optional macro: REGFILE_BYPASS_EN. Rev 1.0
// ============================================================================
module fetch_decode_pipe #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    REG_ADDR_WIDTH = 5,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic [ADDR_WIDTH-1:0]     imem_addr,
  input  logic [31:0]               imem_rdata,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      PCSrc,
  input  logic [ADDR_WIDTH-1:0]     branch_target,
  input  logic                      RegWrite,
  input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  input  logic                      RegDst,
  output logic                      id_valid,
  output logic [31:0]               id_instr,
  output logic [ADDR_WIDTH-1:0]     id_pc_plus4,
  output logic [DATA_WIDTH-1:0]     RD1,
  output logic [DATA_WIDTH-1:0]     RD2,
  output logic [DATA_WIDTH-1:0]     SignImm,
  output logic [REG_ADDR_WIDTH-1:0] id_rs,
  output logic [REG_ADDR_WIDTH-1:0] id_rt,
  output logic [REG_ADDR_WIDTH-1:0] dst_reg
);

  localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  assign pc_plus4  = pc + ADDR_WIDTH'(4);
  assign imem_addr = pc;

  // Redirect wins over stall; the target is forced word aligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else if (PCSrc) begin
      pc <= branch_target & ~ADDR_WIDTH'(3);
    end else if (!stall) begin
      pc <= pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_valid    <= 1'b0;
      id_instr    <= '0;
      id_pc_plus4 <= '0;
    end else if (flush || PCSrc) begin
      id_valid <= 1'b0;
      id_instr <= '0;
    end else if (!stall) begin
      id_valid    <= 1'b1;
      id_instr    <= imem_rdata;
      id_pc_plus4 <= pc_plus4;
    end
  end

  assign id_rs   = REG_ADDR_WIDTH'(id_instr[25:21]);
  assign id_rt   = REG_ADDR_WIDTH'(id_instr[20:16]);
  assign dst_reg = RegDst ? REG_ADDR_WIDTH'(id_instr[15:11]) : id_rt;
  assign SignImm = DATA_WIDTH'($signed(id_instr[15:0]));

  // Register 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (RegWrite && (wb_addr != '0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] rf_read(input logic [REG_ADDR_WIDTH-1:0] idx);
    logic [DATA_WIDTH-1:0] val;
    val = (idx == '0) ? '0 : regs[idx];
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && (wb_addr != '0) && (wb_addr == idx)) begin
      val = wb_data;
    end
`endif
    return val;
  endfunction

  always_comb begin
    RD1 = rf_read(id_rs);
    RD2 = rf_read(id_rt);
  end

endmodule
`default_nettype wire

// File: doc/fetch_decode_pipe.md
Name: fetch_decode_pipe

Overview:
- Parametrised two-stage MIPS front end: PC register plus instruction fetch (IF), an IF/ID pipeline register, then decode (ID) with register-file read, sign extension and destination-register select.
- Adds stall and flush control, branch redirect, a configurable register-file size/width, and a write-back port driven by later stages.
- Sits between the instruction memory and the execute stage of the pipelined core.

Parameters:
- DATA_WIDTH, 32, register-file and immediate width (>= 16).
- ADDR_WIDTH, 32, PC / instruction-address width.
- REG_ADDR_WIDTH, 5, register index width; register file has 2^REG_ADDR_WIDTH entries; instruction fields are truncated to this width.
- RESET_PC, 0, PC value after reset; must be word aligned.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- imem_addr  out  ADDR_WIDTH  fetch address (= current PC).
- imem_rdata  in  32  instruction word; combinational response to imem_addr.
- stall  in  1  hold PC and the IF/ID register.
- flush  in  1  load a bubble into IF/ID.
- PCSrc  in  1  branch/jump redirect request.
- branch_target  in  ADDR_WIDTH  redirect address; bits [1:0] are ignored (forced to 0).
- RegWrite  in  1  write-back enable.
- wb_addr  in  REG_ADDR_WIDTH  write-back register index.
- wb_data  in  DATA_WIDTH  write-back data.
- RegDst  in  1  destination select: 1 = rd (Instr[15:11]), 0 = rt (Instr[20:16]).
- id_valid  out  1  ID stage holds a real instruction.
- id_instr  out  32  ID instruction (0 = NOP when invalid).
- id_pc_plus4  out  ADDR_WIDTH  PC+4 of the ID instruction.
- RD1, RD2  out  DATA_WIDTH  register operands for rs, rt.
- SignImm  out  DATA_WIDTH  sign-extended Instr[15:0].
- id_rs, id_rt, dst_reg  out  REG_ADDR_WIDTH  source indices and selected destination.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc = RESET_PC.
  - id_valid = 0, id_instr = 0, id_pc_plus4 = 0.
  - All registers cleared to 0.
  - Applying reset mid-stream discards all in-flight state immediately, with no clock edge required.
- PC update, per rising edge, in priority order:
  - PCSrc=1: pc <= {branch_target[ADDR_WIDTH-1:2], 2'b00}. Redirect overrides stall.
  - Else stall=1: pc holds.
  - Else: pc <= pc + 4, wrapping modulo 2^ADDR_WIDTH.
- IF/ID register, per rising edge, in priority order:
  - flush=1 or PCSrc=1: id_valid <= 0, id_instr <= 0. Flush overrides stall.
  - Else stall=1: contents hold.
  - Else: id_instr <= imem_rdata, id_pc_plus4 <= pc + 4, id_valid <= 1.
- Latency:
  - Instruction at PC P appears on id_instr one edge after P is presented.
  - The redirect penalty is one bubble.
- Decode is combinational from id_instr:
  - id_rs = Instr[25:21], id_rt = Instr[20:16].
  - dst_reg = RegDst ? Instr[15:11] : Instr[20:16].
  - SignImm = {(DATA_WIDTH-16){Instr[15]}, Instr[15:0]}.
- Register file:
  - Two combinational read ports, indexed by id_rs and id_rt.
  - One synchronous write port on the rising edge when RegWrite=1 and wb_addr != 0.
  - Register 0 always reads 0; writes to it are discarded.
  - Writes are unaffected by stall and flush.
- Simultaneous write and read of the same register: result governed by the optional feature below.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: if RegWrite=1, wb_addr != 0 and wb_addr equals id_rs (resp. id_rt), then RD1 (resp. RD2) = wb_data in the same cycle (write-through forwarding).
- Undefined: RD1/RD2 return the stored value; the new value is visible from the cycle after the write edge.

Test Plan:
- Reset then free-run with imem_rdata = 0x20080005:
  - imem_addr steps 0, 4, 8.
  - After the first edge: id_valid = 1, id_instr = 0x20080005, id_pc_plus4 = 4, SignImm = 0x00000005.
- stall=1 for 2 cycles starting with PC = 8:
  - imem_addr stays 8; id_instr unchanged.
  - Resumes at 12 after stall drops.
- PCSrc=1 with branch_target = 0x00000103 and stall=1:
  - Next imem_addr = 0x100.
  - id_valid = 0 for one cycle, then valid with id_pc_plus4 = 0x104.
- Write-back: RegWrite=1, wb_addr=8, wb_data=0xDEADBEEF; next cycle id_instr has rs=8:
  - RD1 = 0xDEADBEEF.
  - Same-cycle read of rs=8: RD1 = 0xDEADBEEF with REGFILE_BYPASS_EN defined, previous value without it.
- Write to register 0 with 0xFFFFFFFF; instruction with rs=0, rt=0:
  - RD1 = RD2 = 0.
- Wrap and sign/mux checks:
  - RESET_PC = 0xFFFFFFFC: after one edge imem_addr = 0x00000000.
  - Instr = 0x8D09FFF0: SignImm = 0xFFFFFFF0.
  - dst_reg = 9 with RegDst=0, 31 with RegDst=1.
- Assert reset low between clock edges mid-run:
  - pc, id_valid and registers clear immediately, without waiting for a clock edge.
